// File: rtl/alu_8_pkg.sv
// ----------------------------------------------------------------------------
// alu_8_pkg
// Shared definitions for the alu_8 execution unit: the opcode encoding,
// the Z80 flag-byte bit positions and the shifter mode select.
// ----------------------------------------------------------------------------
package alu_8_pkg;

    typedef enum logic [4:0] {
        OP_ADD = 5'd0,
        OP_SUB = 5'd1,
        OP_AND = 5'd2,
        OP_OR  = 5'd3,
        OP_XOR = 5'd4,
        OP_CP  = 5'd5,
        OP_SLL = 5'd6,
        OP_SRL = 5'd7,
        OP_SLA = 5'd8,
        OP_SRA = 5'd9,
        OP_ROL = 5'd10,
        OP_ROR = 5'd11,
        OP_INC = 5'd12,
        OP_DEC = 5'd13,
        OP_SET = 5'd14,
        OP_RES = 5'd15,
        OP_BIT = 5'd16
    } opcode_e;

    // Bit positions inside the Z80 flag byte.
    localparam int FLAG_S  = 7;
    localparam int FLAG_Z  = 6;
    localparam int FLAG_Y  = 5;
    localparam int FLAG_H  = 4;
    localparam int FLAG_X  = 3;
    localparam int FLAG_PV = 2;
    localparam int FLAG_N  = 1;
    localparam int FLAG_C  = 0;

    typedef enum logic [2:0] {
        SH_SLL = 3'd0,
        SH_SRL = 3'd1,
        SH_SRA = 3'd2,
        SH_ROL = 3'd3,
        SH_ROR = 3'd4
    } shift_mode_e;

endpackage

// File: rtl/alu_8_shifter.sv
// ----------------------------------------------------------------------------
// alu_8_shifter
// Combinational barrel unit for the logical/arithmetic shifts and rotates.
//   a_i      : source byte
//   b_i      : shift amount (full byte; rotates use b_i mod 8)
//   mode_i   : SLL / SRL / SRA / ROL / ROR
//   result_o : shifted or rotated byte
//   c_o      : last bit shifted out (sign bit / 0 for out-of-range shifts)
//   hold_c_o : effective amount is zero, so the carry flag must be held
// ----------------------------------------------------------------------------
module alu_8_shifter
    import alu_8_pkg::*;
(
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    input  shift_mode_e mode_i,
    output logic [7:0]  result_o,
    output logic        c_o,
    output logic        hold_c_o
);

    logic [2:0]  amt;
    logic        out_of_range;
    logic [15:0] wide;

    assign amt          = b_i[2:0];
    assign out_of_range = |b_i[7:3];

    // The source is placed in a 16-bit window so the bit adjacent to the
    // kept byte is exactly the last bit that left it.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        result_o = 8'h00;
        c_o      = 1'b0;
        hold_c_o = 1'b0;
        wide     = 16'h0000;
        case (mode_i)
            SH_SLL: begin
                wide     = {8'h00, a_i} << amt;
                result_o = wide[7:0];
                c_o      = wide[8];
                hold_c_o = (b_i == 8'h00);
                if (out_of_range) begin
                    result_o = 8'h00;
                    c_o      = 1'b0;
                end
            end
            SH_SRL: begin
                wide     = {a_i, 8'h00} >> amt;
                result_o = wide[15:8];
                c_o      = wide[7];
                hold_c_o = (b_i == 8'h00);
                if (out_of_range) begin
                    result_o = 8'h00;
                    c_o      = 1'b0;
                end
            end
            SH_SRA: begin
                wide     = $signed({a_i, 8'h00}) >>> amt;
                result_o = wide[15:8];
                c_o      = wide[7];
                hold_c_o = (b_i == 8'h00);
                if (out_of_range) begin
                    result_o = {8{a_i[7]}};
                    c_o      = a_i[7];
                end
            end
            SH_ROL: begin
                wide     = {a_i, a_i} << amt;
                result_o = wide[15:8];
                c_o      = wide[8];     // bit that wrapped into position 0
                hold_c_o = (amt == 3'd0);
            end
            SH_ROR: begin
                wide     = {a_i, a_i} >> amt;
                result_o = wide[7:0];
                c_o      = wide[7];     // bit that wrapped into position 7
                hold_c_o = (amt == 3'd0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_8.sv
// ----------------------------------------------------------------------------
// alu_8
// Registered 8-bit arithmetic/logic/shift unit with a Z80-layout flag byte.
// One-cycle latency, one operation per cycle, no handshake.
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset (clears out and flags)
//   a      : operand A / shift source / bit-op source
//   b      : operand B / shift amount / bit index
//   opcode : operation select (see alu_8_pkg::opcode_e)
//   out    : registered result
//   flags  : registered flags {S,Z,Y,H,X,PV,N,C}
// Build option: define BIT_OPS_EN to enable SET/RES/BIT (opcodes 14-16);
// otherwise they behave as reserved opcodes.
// ----------------------------------------------------------------------------
module alu_8
    import alu_8_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [4:0] opcode,
    output logic [7:0] out,
    output logic [7:0] flags
);

    opcode_e     op;
    logic [7:0]  out_q, out_d;
    logic [7:0]  flags_q, flags_d;

    logic [7:0]  op_b;
    logic [8:0]  sum9, diff9;
    logic [4:0]  half_sum, half_diff;
    logic        add_v, sub_v;
    logic        c_held;

    shift_mode_e sh_mode;
    logic [7:0]  sh_result;
    logic        sh_c, sh_hold;

    logic [7:0]  flag_src;
    logic        h, pv, n, c;
    logic        is_reserved, hold_all, is_bit;
    logic [7:0]  bit_mask;

    assign op     = opcode_e'(opcode);
    assign c_held = flags_q[FLAG_C];

    // INC/DEC reuse the adder/subtractor with a constant operand of 1.
    assign op_b      = (op == OP_INC || op == OP_DEC) ? 8'd1 : b;
    assign sum9      = {1'b0, a} + {1'b0, op_b};
    assign diff9     = {1'b0, a} - {1'b0, op_b};
    assign half_sum  = {1'b0, a[3:0]} + {1'b0, op_b[3:0]};
    assign half_diff = {1'b0, a[3:0]} - {1'b0, op_b[3:0]};
    assign add_v     = (a[7] == op_b[7]) && (sum9[7]  != a[7]);
    assign sub_v     = (a[7] != op_b[7]) && (diff9[7] != a[7]);
    assign bit_mask  = 8'h01 << b[2:0];

    always_comb begin
        sh_mode = SH_SLL;
        case (op)
            OP_SRL:  sh_mode = SH_SRL;
            OP_SRA:  sh_mode = SH_SRA;
            OP_ROL:  sh_mode = SH_ROL;
            OP_ROR:  sh_mode = SH_ROR;
            default: sh_mode = SH_SLL;
        endcase
    end

    alu_8_shifter u_shifter (
        .a_i      (a),
        .b_i      (b),
        .mode_i   (sh_mode),
        .result_o (sh_result),
        .c_o      (sh_c),
        .hold_c_o (sh_hold)
    );

    always_comb begin
        out_d       = 8'h00;
        h           = 1'b0;
        pv          = 1'b0;
        n           = 1'b0;
        c           = 1'b0;
        is_reserved = 1'b0;
        hold_all    = 1'b0;
        is_bit      = 1'b0;
        case (op)
            OP_ADD: begin
                out_d = sum9[7:0];
                c     = sum9[8];
                h     = half_sum[4];
                pv    = add_v;
            end
            OP_SUB, OP_CP: begin
                out_d = (op == OP_CP) ? a : diff9[7:0];
                c     = diff9[8];
                h     = half_diff[4];
                pv    = sub_v;
                n     = 1'b1;
            end
            OP_AND: begin
                out_d = a & b;
                h     = 1'b1;
                pv    = ~^(a & b);
            end
            OP_OR: begin
                out_d = a | b;
                pv    = ~^(a | b);
            end
            OP_XOR: begin
                out_d = a ^ b;
                pv    = ~^(a ^ b);
            end
            OP_SLL, OP_SLA, OP_SRL, OP_SRA, OP_ROL, OP_ROR: begin
                out_d = sh_result;
                c     = sh_hold ? c_held : sh_c;
                pv    = ~^sh_result;
            end
            OP_INC: begin
                out_d = sum9[7:0];
                h     = half_sum[4];
                pv    = add_v;
                c     = c_held;
            end
            OP_DEC: begin
                out_d = diff9[7:0];
                h     = half_diff[4];
                pv    = sub_v;
                n     = 1'b1;
                c     = c_held;
            end
`ifdef BIT_OPS_EN
            OP_SET: begin
                out_d    = a | bit_mask;
                hold_all = 1'b1;
            end
            OP_RES: begin
                out_d    = a & ~bit_mask;
                hold_all = 1'b1;
            end
            OP_BIT: begin
                is_bit = 1'b1;
                h      = 1'b1;
                c      = c_held;
            end
`endif
            default: is_reserved = 1'b1;
        endcase

        // CP reports the subtraction result in S/Z/Y/X while passing A through.
        flag_src = (op == OP_CP) ? diff9[7:0] : out_d;

        flags_d[FLAG_S]  = flag_src[7];
        flags_d[FLAG_Z]  = (flag_src == 8'h00);
        flags_d[FLAG_Y]  = flag_src[5];
        flags_d[FLAG_H]  = h;
        flags_d[FLAG_X]  = flag_src[3];
        flags_d[FLAG_PV] = pv;
        flags_d[FLAG_N]  = n;
        flags_d[FLAG_C]  = c;

        // BIT tests the selected bit of A; PV mirrors Z.
        if (is_bit) begin
            flags_d[FLAG_Z]  = ~|(a & bit_mask);
            flags_d[FLAG_PV] = ~|(a & bit_mask);
        end
        if (hold_all) begin
            flags_d = flags_q;
        end
        if (is_reserved) begin
            flags_d = 8'h00;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q   <= 8'h00;
            flags_q <= 8'h00;
        end else begin
            out_q   <= out_d;
            flags_q <= flags_d;
        end
    end

    assign out   = out_q;
    assign flags = flags_q;

endmodule

// File: tb/tb_alu_8.sv
// ----------------------------------------------------------------------------
// tb_alu_8
// Directed-vector bench for alu_8 with hand-computed result and flag bytes.
// Flag byte layout: {S,Z,Y,H,X,PV,N,C}.
// ----------------------------------------------------------------------------
module tb_alu_8;

    logic       clk;
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic [4:0] opcode;
    logic [7:0] out;
    logic [7:0] flags;

    int n_vec;
    int n_err;

    alu_8 dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
        .opcode (opcode),
        .out    (out),
        .flags  (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 8'h%02h, expected 8'h%02h", tag, got, exp);
        end
    endtask

    // Drive one operation after the falling edge, sample 1 ns after the
    // capturing rising edge, and compare result and flags.
    task automatic vec(input string tag, input logic [4:0] op,
                       input logic [7:0] x, input logic [7:0] y,
                       input logic [7:0] e_out, input logic [7:0] e_flags);
        @(negedge clk);
        opcode = op;
        a      = x;
        b      = y;
        @(posedge clk);
        #1;
        check({tag, ".out"},   out,   e_out);
        check({tag, ".flags"}, flags, e_flags);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec  = 0;
        n_err  = 0;
        rst    = 1'b1;
        a      = 8'h00;
        b      = 8'h00;
        opcode = 5'd0;
        #2;
        check("reset.out",   out,   8'h00);
        check("reset.flags", flags, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Arithmetic and logic.
        vec("add_7_7",    5'd0, 8'h07, 8'h07, 8'h0E, 8'h08);
        vec("sub_7_7",    5'd1, 8'h07, 8'h07, 8'h00, 8'h42);
        vec("and_0d_07",  5'd2, 8'h0D, 8'h07, 8'h05, 8'h14);
        vec("or_cb_2b",   5'd3, 8'hCB, 8'h2B, 8'hEB, 8'hAC);
        vec("xor_ff_8a",  5'd4, 8'hFF, 8'h8A, 8'h75, 8'h20);
        vec("xor_7_7",    5'd4, 8'h07, 8'h07, 8'h00, 8'h44);
        vec("add_80_80",  5'd0, 8'h80, 8'h80, 8'h00, 8'h45);
        vec("add_7f_01",  5'd0, 8'h7F, 8'h01, 8'h80, 8'h94);
        vec("sub_00_01",  5'd1, 8'h00, 8'h01, 8'hFF, 8'hBB);

        // Shifts and rotates.
        vec("sll_07_3",   5'd6, 8'h07, 8'd3,  8'h38, 8'h28);
        vec("sll_0f_6",   5'd6, 8'h0F, 8'd6,  8'hC0, 8'h85);
        vec("sll_0f_9",   5'd6, 8'h0F, 8'd9,  8'h00, 8'h44);
        vec("srl_ca_3",   5'd7, 8'hCA, 8'd3,  8'h19, 8'h08);
        vec("srl_ca_8",   5'd7, 8'hCA, 8'd8,  8'h00, 8'h44);
        vec("sla_07_3",   5'd8, 8'h07, 8'd3,  8'h38, 8'h28);
        vec("sla_0f_6",   5'd8, 8'h0F, 8'd6,  8'hC0, 8'h85);
        vec("sla_0f_9",   5'd8, 8'h0F, 8'd9,  8'h00, 8'h44);
        vec("sra_ca_3",   5'd9, 8'hCA, 8'd3,  8'hF9, 8'hAC);
        vec("sra_4a_3",   5'd9, 8'h4A, 8'd3,  8'h09, 8'h0C);
        vec("sra_ca_8",   5'd9, 8'hCA, 8'd8,  8'hFF, 8'hAD);
        vec("rol_81_8",   5'd10, 8'h81, 8'd8, 8'h81, 8'h85);  // amount 0: C held at 1
        vec("sra_4a_8",   5'd9, 8'h4A, 8'd8,  8'h00, 8'h44);
        vec("rol_ca_3",   5'd10, 8'hCA, 8'd3, 8'h56, 8'h04);
        vec("rol_80_10",  5'd10, 8'h80, 8'd10, 8'h02, 8'h00);
        vec("ror_01_1",   5'd11, 8'h01, 8'd1, 8'h80, 8'h81);
        vec("sll_10_0",   5'd6, 8'h10, 8'd0,  8'h10, 8'h01);  // amount 0: C held at 1

        // CP, then INC/DEC holding the carry that CP produced.
        vec("cp_05_07",   5'd5, 8'h05, 8'h07, 8'h05, 8'hBB);
        vec("inc_7f",     5'd12, 8'h7F, 8'h00, 8'h80, 8'h95);
        vec("dec_80",     5'd13, 8'h80, 8'h00, 8'h7F, 8'h3F);

`ifdef BIT_OPS_EN
        vec("set_7_7",    5'd14, 8'h07, 8'h07, 8'h87, 8'h3F);
        vec("res_7_7",    5'd15, 8'h07, 8'h07, 8'h07, 8'h3F);
        vec("bit_7_7",    5'd16, 8'h07, 8'h07, 8'h00, 8'h55);
`else
        vec("op14_7_7",   5'd14, 8'h07, 8'h07, 8'h00, 8'h00);
        vec("op15_7_7",   5'd15, 8'h07, 8'h07, 8'h00, 8'h00);
        vec("op16_7_7",   5'd16, 8'h07, 8'h07, 8'h00, 8'h00);
`endif
        vec("op20_7_7",   5'd20, 8'h07, 8'h07, 8'h00, 8'h00);
        vec("op31_ff_ff", 5'd31, 8'hFF, 8'hFF, 8'h00, 8'h00);

        // Asynchronous reset mid-stream, then recovery.
        vec("pre_rst",    5'd0, 8'h7F, 8'h01, 8'h80, 8'h94);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst.out",   out,   8'h00);
        check("async_rst.flags", flags, 8'h00);
        opcode = 5'd0;
        a      = 8'h07;
        b      = 8'h07;
        @(posedge clk);
        #1;
        check("rst_hold.out",   out,   8'h00);
        check("rst_hold.flags", flags, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        vec("post_rst_add", 5'd0, 8'h07, 8'h07, 8'h0E, 8'h08);
        vec("post_rst_inc", 5'd12, 8'h0F, 8'h00, 8'h10, 8'h10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_8.md
# alu_8

Registered 8-bit arithmetic/logic/shift unit for the Z80 execution datapath. Each cycle it takes two 8-bit operands and a 5-bit opcode and produces an 8-bit result plus a Z80-layout flag byte, both registered on the rising clock edge. It sits between the register file read ports and the write-back mux. It holds no state beyond the output and flag registers.

## Interface
- No parameters. Width is fixed at 8.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- a  input  8  operand A; also the shift/rotate/bit-op source.
- b  input  8  operand B; also the shift/rotate amount or the bit index.
- opcode  input  5  operation select.
- out  output  8  registered result.
- flags  output  8  registered flags in Z80 layout: [7]S [6]Z [5]Y [4]H [3]X [2]PV [1]N [0]C.

## Operation
- 0 ADD: out = a+b mod 256. C = carry out of bit 7. H = carry out of bit 3. PV = signed overflow. N=0.
- 1 SUB: out = a−b mod 256. C = borrow. H = borrow from bit 4. PV = signed overflow. N=1.
- 2 AND: out = a&b. H=1, C=0, N=0, PV = even parity of out.
- 3 OR: out = a|b. H=0, C=0, N=0, PV = parity.
- 4 XOR: out = a^b. H=0, C=0, N=0, PV = parity.
- 5 CP: flags exactly as SUB. out = a (unchanged).
- 6 SLL and 8 SLA (identical): out = a << b. If b ≥ 8, out=0.
- 7 SRL: out = a >> b, zero fill. If b ≥ 8, out=0.
- 9 SRA: arithmetic shift, sign fill. If b ≥ 8, out = 8'hFF when a[7]=1, else 8'h00.
- 10 ROL: rotate left by b mod 8.
- 11 ROR: rotate right by b mod 8.
- Shift/rotate flags:
  - C = last bit shifted out. For out-of-range shifts, C = sign bit for SRA and 0 otherwise.
  - If the effective amount is 0, C is held at its previous value.
  - H=0, N=0, PV = parity.
- 12 INC: out = a+1. 13 DEC: out = a−1.
  - H and PV are computed as for ADD/SUB with operand 1.
  - N=0 for INC, N=1 for DEC.
  - C is held at its previous registered value.
- 14 SET, 15 RES, 16 BIT: see Configuration.
- 17–31 reserved: out = 0, flags = 0.
- All ops: S = out[7], Z = (out==0), Y = out[5], X = out[3], unless stated otherwise.

## Timing
- One-cycle latency: operands and opcode present before rising edge k appear on out/flags after edge k.
- A new operation may issue every cycle. There is no handshake and no stall.
- rst asserted: out = 8'h00 and flags = 8'h00 immediately, independent of clk.
- Reset wins over a simultaneous clock edge. The first operation is captured on the first rising edge after rst deasserts.
- "Held" C means the value in the flags register before the edge; after reset that value is 0.

## Configuration
- BIT_OPS_EN defined:
  - SET: out = a | (1<<b[2:0]).
  - RES: out = a & ~(1<<b[2:0]).
  - BIT: out = 0; Z = ~a[b[2:0]]; H=1; N=0; PV = Z; C held; S and Y/X as normal.
  - SET and RES leave all flags held.
- BIT_OPS_EN undefined: opcodes 14–16 behave as reserved (out = 0, flags = 0).

## Structure
- Package alu_8_pkg holds the opcode enum (ADD..BIT values 0–16) and the flag bit-index constants (FLAG_S..FLAG_C).
- Sub-module alu_8_shifter: a combinational barrel unit covering SLL/SRL/SRA/ROL/ROR. It takes a, b and a mode select, and returns the result and the shifted-out bit.

## Test plan
- ADD a=7, b=7 → out 14 (8'h0E), Z=0, C=0. SUB a=7, b=7 → out 0, Z=1, N=1. AND 8'h0D, 8'h07 → out 8'h05, H=1.
- OR 8'hCB, 8'h2B → out 8'hEB. XOR 8'hFF, 8'h8A → out 8'h75. XOR 7, 7 → out 0, Z=1.
- Shifts:
  - SLL 8'h07 by 3 → 8'h38; 8'h0F by 6 → 8'hC0; 8'h0F by 9 → 8'h00.
  - SRL 8'hCA by 3 → 8'h19; 8'hCA by 8 → 8'h00.
  - SLA gives the same results as SLL.
- SRA 8'hCA by 3 → 8'hF9. SRA 8'h4A by 3 → 8'h09. SRA 8'hCA by 8 → 8'hFF. SRA 8'h4A by 8 → 8'h00.
- ROL 8'hCA by 3 → 8'h56. ROL 8'h80 by 10 → 8'h02.
- Bit ops and reset:
  - Without BIT_OPS_EN, opcodes 14/15/16 with a=7, b=7 → out 0.
  - With BIT_OPS_EN, SET gives 8'h87, RES gives 8'h07, BIT gives Z=1.
  - Asserting rst mid-stream clears out and flags with no clock edge.
